// File: rtl/stage2_pkg.sv
// -----------------------------------------------------------------------------
// stage2_pkg
// Constants and types shared by the stage-2 bank writer and the stage-2 reader.
// Both sides take the frame geometry from here, so the order the writer fills
// the banks and the order the reader walks them cannot drift apart.
//   DATA_W      width of one operand word
//   N_BANKS     number of banks, one per multiplication pass
//   BANK_DEPTH  words per bank
//   ADDR_W      word address width within a bank
//   BANK_W      bank select width
//   LAST_ADDR   final word address inside a bank
//   LAST_BANK   final bank index of a frame
// -----------------------------------------------------------------------------
package stage2_pkg;

    localparam int DATA_W     = 16;
    localparam int N_BANKS    = 4;
    localparam int BANK_DEPTH = 36;
    localparam int ADDR_W     = 6;
    localparam int BANK_W     = 2;

    localparam int LAST_ADDR  = BANK_DEPTH - 1;
    localparam int LAST_BANK  = N_BANKS - 1;

    // Writer frame state.
    typedef enum logic [1:0] {
        FILL  = 2'd0,   // accepting words of the current frame
        FLUSH = 2'd1,   // last word's write is on the port
        READY = 2'd2    // full frame stored, waiting for the reader
    } wr_state_t;

endpackage

// File: rtl/bank_addr_counter.sv
// -----------------------------------------------------------------------------
// bank_addr_counter
// Bank-major position counter over a frame of N_BANKS x BANK_DEPTH words:
// the address runs 0..BANK_DEPTH-1, then wraps to 0 while the bank steps.
// After the last word of the last bank both fields return to 0, ready for the
// next frame. Shared by the writer and the reader of the stage-2 banks.
// Ports
//   clk     in   clock, rising edge
//   clr_i   in   synchronous clear to bank 0 / addr 0 (wins over inc_i)
//   inc_i   in   advance one word
//   bank_o  out  current bank
//   addr_o  out  current word address within the bank
//   last_o  out  current position is the final word of the frame
// -----------------------------------------------------------------------------
module bank_addr_counter
    import stage2_pkg::*;
#(
    parameter int N_BANKS_P    = N_BANKS,
    parameter int BANK_DEPTH_P = BANK_DEPTH,
    parameter int ADDR_W_P     = ADDR_W,
    parameter int BANK_W_P     = BANK_W
) (
    input  logic                clk,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [BANK_W_P-1:0] bank_o,
    output logic [ADDR_W_P-1:0] addr_o,
    output logic                last_o
);

    localparam logic [ADDR_W_P-1:0] ADDR_LAST = ADDR_W_P'(BANK_DEPTH_P - 1);
    localparam logic [BANK_W_P-1:0] BANK_LAST = BANK_W_P'(N_BANKS_P - 1);

    logic [BANK_W_P-1:0] bank_q, bank_d;
    logic [ADDR_W_P-1:0] addr_q, addr_d;
    logic                addr_wrap;

    assign addr_wrap = (addr_q == ADDR_LAST);
    assign last_o    = addr_wrap && (bank_q == BANK_LAST);

    always_comb begin
        bank_d = bank_q;
        addr_d = addr_q;
        if (clr_i) begin
            bank_d = '0;
            addr_d = '0;
        end else if (inc_i) begin
            if (last_o) begin
                // End of frame: both fields restart, so the bank never
                // counts past the last one.
                bank_d = '0;
                addr_d = '0;
            end else if (addr_wrap) begin
                bank_d = bank_q + BANK_W_P'(1);
                addr_d = '0;
            end else begin
                addr_d = addr_q + ADDR_W_P'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the pre-edge value of its inputs, independent of the
    // order in which the simulator evaluates always blocks.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
        addr_q <= addr_d;
    end

    assign bank_o = bank_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/stage2_bank_writer.sv
// -----------------------------------------------------------------------------
// stage2_bank_writer
// Write side of the stage-2 operand banks. Takes a valid/ready word stream and
// stores it bank-major (bank 0 addr 0..35, then bank 1, ...), which is the
// order the stage-2 control FSM reads it back. Once the final word is written
// it raises data_rdy and refuses further input until stage 2 reports
// data_done, so a frame is never overwritten while it is being read.
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   in_valid   in   upstream word valid
//   in_data    in   upstream word
//   in_ready   out  a word can be accepted this cycle (state only)
//   wr_en      out  bank write strobe, one cycle after the accept
//   wr_bank    out  bank select of the write
//   wr_addr    out  word address of the write
//   wr_data    out  write data
//   data_rdy   out  full frame stored, stage 2 may start
//   data_done  in   stage 2 finished reading the frame
// -----------------------------------------------------------------------------
module stage2_bank_writer
    import stage2_pkg::*;
#(
    parameter int DATA_W_P     = DATA_W,
    parameter int N_BANKS_P    = N_BANKS,
    parameter int BANK_DEPTH_P = BANK_DEPTH,
    parameter int ADDR_W_P     = ADDR_W,
    parameter int BANK_W_P     = BANK_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [DATA_W_P-1:0] in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [BANK_W_P-1:0] wr_bank,
    output logic [ADDR_W_P-1:0] wr_addr,
    output logic [DATA_W_P-1:0] wr_data,
    output logic                data_rdy,
    input  logic                data_done
);

    wr_state_t           state_q, state_d;
    logic                accept;
    logic [BANK_W_P-1:0] cnt_bank;
    logic [ADDR_W_P-1:0] cnt_addr;
    logic                cnt_last;

    logic                wr_en_q;
    logic [BANK_W_P-1:0] wr_bank_q;
    logic [ADDR_W_P-1:0] wr_addr_q;
    logic [DATA_W_P-1:0] wr_data_q;
    logic                data_rdy_q;

    // Ready is a function of state alone, so upstream may hold in_valid high
    // through FLUSH/READY and the word simply waits.
    assign in_ready = (state_q == FILL);
    assign accept   = in_valid && in_ready;

    // Reset doubles as the counter clear: a partial frame is discarded and
    // the next frame starts at bank 0, addr 0.
    bank_addr_counter #(
        .N_BANKS_P    (N_BANKS_P),
        .BANK_DEPTH_P (BANK_DEPTH_P),
        .ADDR_W_P     (ADDR_W_P),
        .BANK_W_P     (BANK_W_P)
    ) u_cnt (
        .clk    (clk),
        .clr_i  (reset),
        .inc_i  (accept),
        .bank_o (cnt_bank),
        .addr_o (cnt_addr),
        .last_o (cnt_last)
    );

    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (accept && cnt_last) state_d = FLUSH;
            FLUSH:   state_d = READY;
            // data_done only matters here; a stale level seen in FILL or
            // FLUSH cannot skip a frame.
            READY:   if (data_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            data_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered copy of (state == READY): rises one cycle after the
            // last write strobe, drops the cycle after data_done.
            data_rdy_q <= (state_d == READY);
        end
    end

    // Write port: an accept in cycle t is presented in cycle t+1. Address and
    // data hold their last value while wr_en is low.
    // NOTE: the write datapath is reset too, not only the strobe, because the
    // port must read all-zero after reset rather than stale frame contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_bank_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_bank_q <= cnt_bank;
                wr_addr_q <= cnt_addr;
                wr_data_q <= in_data;
            end
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_bank  = wr_bank_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign data_rdy = data_rdy_q;

endmodule

// File: tb/tb_stage2_bank_writer.sv
// -----------------------------------------------------------------------------
// tb_stage2_bank_writer
// Directed table for reset/first-write behaviour, then a reference model with
// a write scoreboard across whole frames, gaps, stray data_done and reset.
// -----------------------------------------------------------------------------
module tb_stage2_bank_writer;

    localparam int FRAME = 144;
    localparam int DEPTH = 36;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        data_rdy;
    logic        data_done;

    always #5 clk = ~clk;

    stage2_bank_writer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .data_rdy  (data_rdy),
        .data_done (data_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        v;
        logic [15:0] d;
        logic        dn;
        logic        e_in_ready;
        logic        e_wr_en;
        logic [1:0]  e_bank;
        logic [5:0]  e_addr;
        logic [15:0] e_data;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[8];

    // ---------------- reference model + scoreboard ----------------
    typedef enum int {M_FILL, M_FLUSH, M_READY} m_state_t;
    m_state_t    m_state;
    int          m_k;          // index of the next word in the frame
    bit          m_exp_wr;     // an accept happened in the previous cycle
    bit          m_last_acc;
    bit          prev_rdy;
    int          rdy_rises;
    logic [23:0] sb[$];        // {bank, addr, data}

    // Called just after a rising edge: drive, observe at the falling edge,
    // then advance the model across the next rising edge.
    task automatic step(input logic v, input logic [15:0] d, input logic dn);
        logic [23:0] exp_w;
        in_valid  = v;
        in_data   = d;
        data_done = dn;
        @(negedge clk);
        check("wr_en", wr_en, m_exp_wr);
        if (wr_en && m_exp_wr) begin
            exp_w = sb.pop_front();
            check("write", {wr_bank, wr_addr, wr_data}, exp_w);
        end
        check("in_ready", in_ready, m_state == M_FILL);
        check("data_rdy", data_rdy, m_state == M_READY);
        if (data_rdy && !prev_rdy) rdy_rises++;
        prev_rdy   = data_rdy;
        m_last_acc = v && (m_state == M_FILL);
        if (m_last_acc)
            sb.push_back({2'(m_k / DEPTH), 6'(m_k % DEPTH), d});
        @(posedge clk);
        m_exp_wr = m_last_acc;
        case (m_state)
            M_FILL:  if (m_last_acc) begin
                         if (m_k == FRAME - 1) begin
                             m_k     = 0;
                             m_state = M_FLUSH;
                         end else begin
                             m_k++;
                         end
                     end
            M_FLUSH: m_state = M_READY;
            M_READY: if (dn) m_state = M_FILL;
            default: m_state = M_FILL;
        endcase
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_done = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_data_rdy", data_rdy, 0);
        check("rst_in_ready", in_ready, 1);
        m_state  = M_FILL;
        m_k      = 0;
        m_exp_wr = 0;
        prev_rdy = 0;
        sb.delete();
    endtask

    // Feed n_words accepted words. gaps: 50% random in_valid. data_done is
    // held at dn_hold, and additionally pulsed while word pulse_at is due.
    task automatic fill(input int n_words, input bit gaps, input logic dn_hold, input int pulse_at);
        int budget = 4000;
        int got    = 0;
        logic v;
        logic dn;
        logic [15:0] d;
        while (got < n_words && budget > 0) begin
            v  = gaps ? logic'($urandom_range(0, 1)) : 1'b1;
            d  = gaps ? 16'($urandom) : 16'(m_k);
            dn = dn_hold || (m_k == pulse_at);
            step(v, d, dn);
            if (m_last_acc) got++;
            budget--;
        end
        check("fill_budget", budget > 0, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        data_done = 1'b0;
        rdy_rises = 0;

        //           rst   v     d        dn    rdyin wr    bank  addr  data     drdy
        vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 2'd0, 6'd0, 16'hAAAA, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 2'd0, 6'd0, 16'hAAAA, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 2'd0, 6'd1, 16'h1234, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h5678, 1'b0, 1'b1, 1'b1, 2'd0, 6'd2, 16'h5678, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0042, 1'b0, 1'b1, 1'b1, 2'd0, 6'd0, 16'h0042, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h7777, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0, 16'h0042, 1'b0};

        for (int i = 0; i < 8; i++) begin
            reset     = vecs[i].rst;
            in_valid  = vecs[i].v;
            in_data   = vecs[i].d;
            data_done = vecs[i].dn;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
            check($sformatf("vec%0d_wr_en", i),    wr_en,    vecs[i].e_wr_en);
            check($sformatf("vec%0d_wr_bank", i),  wr_bank,  vecs[i].e_bank);
            check($sformatf("vec%0d_wr_addr", i),  wr_addr,  vecs[i].e_addr);
            check($sformatf("vec%0d_wr_data", i),  wr_data,  vecs[i].e_data);
            check($sformatf("vec%0d_data_rdy", i), data_rdy, vecs[i].e_rdy);
        end

        // 1: back-to-back frame 0..143, data_rdy two cycles after last accept
        do_reset();
        fill(FRAME, 0, 1'b0, -1);
        step(1'b0, 16'h0, 1'b0);       // FLUSH: last write on the port
        check("t1_flush_rdy_low", data_rdy, 1'b1);   // sampled #1 after the second edge
        step(1'b0, 16'h0, 1'b0);       // READY

        // 2: in_valid held during READY is not consumed
        for (int i = 0; i < 10; i++) step(1'b1, 16'hBEEF, 1'b0);
        step(1'b1, 16'hBEEF, 1'b1);    // data_done pulse
        fill(FRAME, 0, 1'b0, -1);      // first word must land at bank 0 addr 0
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        // 3: random valid gaps across a frame
        step(1'b0, 16'h0, 1'b1);
        fill(FRAME, 1, 1'b0, -1);
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        // 4: data_done during FILL (after word 20) and during FLUSH is ignored
        step(1'b0, 16'h0, 1'b1);
        fill(FRAME, 0, 1'b0, 21);
        step(1'b0, 16'h0, 1'b1);       // FLUSH with data_done high
        step(1'b0, 16'h0, 1'b0);       // READY must still be reached
        check("t4_rdy", data_rdy, 1'b1);

        // 5: reset after word 70 (bank 1 addr 34), then a full frame
        step(1'b0, 16'h0, 1'b1);
        fill(71, 0, 1'b0, -1);
        do_reset();
        fill(FRAME, 0, 1'b0, -1);
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        // 6: data_done held high from READY through the next frame
        rdy_rises = 0;
        prev_rdy  = 1'b1;
        step(1'b0, 16'h0, 1'b1);       // READY -> FILL
        fill(FRAME, 0, 1'b1, -1);
        step(1'b0, 16'h0, 1'b1);       // FLUSH
        step(1'b0, 16'h0, 1'b1);       // READY, left again immediately
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        check("t6_rdy_rises", rdy_rises, 1);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
